// File: rtl/host_iface_pkg.sv
// host_iface_pkg: shared state encoding, width helper and source indices for the host output path
package host_iface_pkg;
  typedef enum logic {OMUX_IDLE = 1'b0, OMUX_SEND = 1'b1} omux_state_t;
  localparam int SRC_REGMAN = 0;
  localparam int SRC_TAGS = 1;
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/omux_rr_pick.sv
// omux_rr_pick: winner selection after `last`, or lowest index when OMUX_FIXED_PRIO_EN is defined
module omux_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         valid
);
  assign valid = |req;
`ifdef OMUX_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  // lowest-index requester wins; scanning downwards lets the smallest index overwrite
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
`else
  // first requester at last+1, last+2, ... wraps modulo N; closest distance overwrites last
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--) if (req[(int'(last) + i) % N]) idx = W'((int'(last) + i) % N);
  end
`endif
endmodule

// File: rtl/out_arbiter.sv
// out_arbiter: bounded-burst arbiter merging source byte streams onto one output (OMUX_FIXED_PRIO_EN selects fixed priority)
module out_arbiter
  import host_iface_pkg::*;
#(
  parameter int N_SRCS = 4,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N_SRCS*DATA_W-1:0] src_data_i,
  input  logic [N_SRCS-1:0]        src_req_i,
  output logic [N_SRCS-1:0]        src_sel_o,
  output logic [N_SRCS-1:0]        grant_o,
  output logic [DATA_W-1:0]        out_o,
  output logic                     out_req_o,
  input  logic                     out_ack_i,
  output logic                     busy_o
);
  localparam int IDX_W = width_of(N_SRCS);
  localparam int CNT_W = width_of(MAX_BURST + 1);
  omux_state_t      state;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] burst_cnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             accept;
  logic             last_byte;
  omux_rr_pick #(.N(N_SRCS), .W(IDX_W)) u_pick (
    .req   (src_req_i),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  assign busy_o    = (state == OMUX_SEND);
  assign out_req_o = busy_o & src_req_i[cur];
  assign out_o     = out_req_o ? src_data_i[cur*DATA_W +: DATA_W] : '0;
  assign accept    = out_req_o & out_ack_i;
  assign last_byte = accept & (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign src_sel_o = accept ? N_SRCS'(1) << cur : '0;
  assign grant_o   = busy_o ? N_SRCS'(1) << cur : '0;
  // grant in IDLE, count accepted bytes in SEND, leave on source drop or burst limit
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= OMUX_IDLE;
      cur       <= '0;
      last      <= IDX_W'(N_SRCS - 1);
      burst_cnt <= '0;
    end else if (state == OMUX_IDLE) begin
      if (pick_valid) begin
        cur       <= pick_idx;
        burst_cnt <= '0;
        state     <= OMUX_SEND;
      end
    end else begin
      if (accept) burst_cnt <= burst_cnt + 1'b1;
      if (!src_req_i[cur] || last_byte) begin
        state <= OMUX_IDLE;
        last  <= cur;
      end
    end
  end
endmodule

// File: tb/tb_out_arbiter.sv
// tb_out_arbiter: directed checks of single-source, contention, backpressure, drop and async reset
module tb_out_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src_data = {8'h43, 8'h32, 8'hA5, 8'h10};
  logic [3:0]  src_req = '0;
  logic [3:0]  src_sel;
  logic [3:0]  grant;
  logic [7:0]  out;
  logic        out_req;
  logic        out_ack = 1'b0;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
`ifdef OMUX_FIXED_PRIO_EN
  localparam logic [3:0] SECOND = 4'b0001;
`else
  localparam logic [3:0] SECOND = 4'b0100;
`endif
  out_arbiter #(.N_SRCS(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .src_data_i (src_data),
    .src_req_i  (src_req),
    .src_sel_o  (src_sel),
    .grant_o    (grant),
    .out_o      (out),
    .out_req_o  (out_req),
    .out_ack_i  (out_ack),
    .busy_o     (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    src_req = '0;
    out_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    step();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_req", out_req, 0);
    check("rst_sel", src_sel, 0);
    check("rst_out", out, 0);
    do_reset();
    // single source 1, three bytes then drop with a stray ack
    src_req = 4'b0010;
    out_ack = 1'b1;
    step();
    for (int j = 0; j < 3; j++) begin
      check("single_grant", grant, 4'b0010);
      check("single_out", out, 8'hA5);
      check("single_req", out_req, 1);
      check("single_sel", src_sel, 4'b0010);
      step();
    end
    src_req = 4'b0000;
    #1;
    check("single_drop_req", out_req, 0);
    check("single_drop_sel", src_sel, 0);
    check("single_drop_out", out, 0);
    step();
    check("single_idle_busy", busy, 0);
    check("single_idle_grant", grant, 0);
    // contention between sources 0 and 2
    do_reset();
    src_req = 4'b0101;
    out_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step();
      for (int j = 0; j < 4; j++) begin
        check("cont_grant", grant, b[0] ? SECOND : 4'b0001);
        check("cont_sel", src_sel, b[0] ? SECOND : 4'b0001);
        if (j < 3) step();
      end
      step();
      check("cont_gap_busy", busy, 0);
      check("cont_gap_sel", src_sel, 0);
    end
    // backpressure on source 3
    do_reset();
    src_req = 4'b1000;
    out_ack = 1'b1;
    step();
    check("bp_first_sel", src_sel, 4'b1000);
    out_ack = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      check("bp_req", out_req, 1);
      check("bp_out", out, 8'h43);
      check("bp_sel", src_sel, 0);
      check("bp_busy", busy, 1);
    end
    out_ack = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check("bp_resume_sel", src_sel, 4'b1000);
    end
    step();
    check("bp_limit_busy", busy, 0);
    // owner drop after two bytes, next requester granted
    do_reset();
    src_req = 4'b0011;
    out_ack = 1'b1;
    step();
    check("drop_b1", src_sel, 4'b0001);
    step();
    check("drop_b2", src_sel, 4'b0001);
    src_req = 4'b0010;
    #1;
    check("drop_stray_sel", src_sel, 0);
    check("drop_stray_req", out_req, 0);
    step();
    check("drop_idle_busy", busy, 0);
    step();
    check("drop_next_grant", grant, 4'b0010);
    check("drop_next_sel", src_sel, 4'b0010);
    // asynchronous reset between edges
    do_reset();
    src_req = 4'b0100;
    step();
    check("ar_grant", grant, 4'b0100);
    check("ar_out", out, 8'h32);
    #2;
    rst = 1'b1;
    #1;
    check("ar_grant0", grant, 0);
    check("ar_busy0", busy, 0);
    check("ar_req0", out_req, 0);
    check("ar_out0", out, 0);
    step();
    rst = 1'b0;
    src_req = 4'b1111;
    step();
    check("ar_restart_grant", grant, 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/out_arbiter.md
Name: out_arbiter

Overview:
- Next-generation output multiplexer for the host interface.
- Merges N_SRCS independent byte streams (register-manager replies, tag data, status) into the single FT2232 transmit path (out_req/out_ack).
- Each source has its own data bus.
- Arbitration is round-robin with a bounded burst length, so the tag stream cannot starve register replies.

Parameters:
N_SRCS, 4, number of writer sources (1..16)
DATA_W, 8, width of each source data bus and of out_o
MAX_BURST, 64, maximum bytes accepted from one grant before forced re-arbitration (1..65535)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
src_data_i  in  N_SRCS*DATA_W  per-source data; source k occupies bits [k*DATA_W +: DATA_W]
src_req_i  in  N_SRCS  source k has a byte ready; held with data stable until its src_sel_o pulse
src_sel_o  out  N_SRCS  one-cycle pulse: byte from source k consumed this cycle
grant_o  out  N_SRCS  one-hot; current burst owner, zero when idle
out_o  out  DATA_W  byte to the FT2232 block
out_req_o  out  1  out_o valid
out_ack_i  in  1  FT2232 block consumed out_o this cycle
busy_o  out  1  a burst is in progress (state SEND)

Behaviour:
- Reset values: all outputs 0, state IDLE, cur=0, last=N_SRCS-1, burst_cnt=0.
- Reset asserted mid-burst aborts the burst immediately. No sel pulse is issued for the in-flight byte.
- States: IDLE, SEND (1 bit).
- IDLE:
  - If src_req_i != 0, choose winner = first set bit searching last+1, last+2, ... modulo N_SRCS.
  - Register cur<=winner, burst_cnt<=0, state<=SEND.
  - grant_o becomes valid the cycle after the request is first seen.
- SEND:
  - out_req_o = src_req_i[cur] (combinational).
  - out_o = src_data_i slice cur (combinational). out_o is zero when out_req_o is low.
  - out_ack_i && out_req_o: src_sel_o[cur]=1 same cycle, burst_cnt<=burst_cnt+1.
  - out_ack_i while out_req_o is low is ignored (no pulse, no count).
- SEND exit to IDLE (last<=cur):
  - on the accepting cycle when burst_cnt==MAX_BURST-1, or
  - any cycle with src_req_i[cur]==0.
- Minimum one IDLE cycle between bursts. Worst-case throughput is therefore MAX_BURST/(MAX_BURST+1) per contended grant.
- Round-robin guarantee: a continuously requesting source waits at most (N_SRCS-1) bursts.
- Simultaneous events:
  - A new request arriving in the same cycle a burst ends is considered in the next IDLE cycle.
  - Ack on the final burst byte gives both a sel pulse and the exit.
- burst_cnt is $clog2(MAX_BURST+1) bits wide and never wraps (reset at grant).
- src_sel_o is at most one-hot. grant_o equals 1<<cur in SEND, 0 in IDLE.

Optional Feature:
- Macro: OMUX_FIXED_PRIO_EN.
- Defined: IDLE picks the lowest-index requester (legacy behaviour; register manager on source 0 always wins), and `last` is unused.
- Undefined: round-robin as above.
- MAX_BURST limiting applies in both modes.

Decomposition:
- host_iface_pkg holds:
  - state encoding constants OMUX_IDLE/OMUX_SEND
  - a width function for the index and counter widths
  - default source indices (SRC_REGMAN=0, SRC_TAGS=1)
- Sub-module omux_rr_pick: combinational winner selection from req vector and last pointer, outputs index and valid. Swapped for a priority encoder under OMUX_FIXED_PRIO_EN.

Test Plan:
- Single source: src 1 req with 0xA5, ack every cycle for 3 bytes then req drops -> grant_o=0010, three sel pulses on bit 1, out_o=0xA5 while out_req_o, returns IDLE, busy_o=0.
- Contention: srcs 0 and 2 requesting continuously, MAX_BURST=4, ack always -> grant sequence 0,2,0,2, each burst exactly 4 sel pulses, 1 idle cycle between bursts.
- Backpressure: ack held low for 10 cycles mid-burst -> out_req_o stays 1, out_o stable, no sel pulse, burst_cnt unchanged.
- Source drop: owner deasserts req after 2 of 64 bytes -> exit next cycle, next requester granted, stray ack while out_req_o=0 produces no sel.
- Async reset mid-burst: reset_i pulsed between edges -> all outputs 0 immediately; after release, the round-robin search restarts from source 0.
- OMUX_FIXED_PRIO_EN build: srcs 0 and 3 requesting, MAX_BURST=2 -> src 0 granted every time, src 3 only after src 0 drops req.
